multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// a sticky illegal-opcode trap. Pulse outputs are decoded from the registered state.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_data,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic [2:0]  imm_sel,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR
  } cls_t;

  state_t     r_state, w_next;
  cls_t       r_cls, w_dec_cls;
  logic       w_dec_ok;
  logic [2:0] w_dec_imm, r_imm;
  logic       w_dec_srcb, r_srcb;
  logic       r_illegal;
  logic       w_rd_nz;
  logic       w_unused;

  assign w_rd_nz  = |instr[11:7];
  assign w_unused = ^instr[31:12];

  // Opcode decode; only consumed while in DECODE.
  always_comb begin
    w_dec_ok   = 1'b1;
    w_dec_cls  = C_R;
    w_dec_imm  = 3'b000;
    w_dec_srcb = 1'b0;
    case (instr[6:0])
      7'b0110011: begin w_dec_cls = C_R;      w_dec_imm = 3'b000; w_dec_srcb = 1'b0; end
      7'b0010011: begin w_dec_cls = C_IALU;   w_dec_imm = 3'b001; w_dec_srcb = 1'b1; end
      7'b0000011: begin w_dec_cls = C_LOAD;   w_dec_imm = 3'b001; w_dec_srcb = 1'b1; end
      7'b0100011: begin w_dec_cls = C_STORE;  w_dec_imm = 3'b010; w_dec_srcb = 1'b1; end
      7'b1100011: begin w_dec_cls = C_BRANCH; w_dec_imm = 3'b011; w_dec_srcb = 1'b0; end
      7'b0110111: begin w_dec_cls = C_LUI;    w_dec_imm = 3'b100; w_dec_srcb = 1'b1; end
      7'b0010111: begin w_dec_cls = C_AUIPC;  w_dec_imm = 3'b100; w_dec_srcb = 1'b1; end
      7'b1101111: begin w_dec_cls = C_JAL;    w_dec_imm = 3'b101; w_dec_srcb = 1'b1; end
      7'b1100111: begin w_dec_cls = C_JALR;   w_dec_imm = 3'b001; w_dec_srcb = 1'b1; end
      default:    w_dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: w_next = w_dec_ok ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (r_cls == C_LOAD || r_cls == C_STORE) w_next = S_MEM;
        else if (r_cls == C_BRANCH)              w_next = S_FETCH;
        else                                     w_next = S_WB;
      end
      S_MEM:    if (mem_ready) w_next = (r_cls == C_STORE) ? S_FETCH : S_WB;
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  // Decode results are latched on DECODE exit and dropped on every return to FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_cls     <= C_R;
      r_imm     <= 3'b000;
      r_srcb    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        if (w_dec_ok) begin
          r_cls  <= w_dec_cls;
          r_imm  <= w_dec_imm;
          r_srcb <= w_dec_srcb;
        end else begin
          r_illegal <= 1'b1;
        end
      end
      if (w_next == S_FETCH) begin
        r_imm  <= 3'b000;
        r_srcb <= 1'b0;
      end
    end
  end

  // Everything is gated by rst so outputs clear the instant reset asserts.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    reg_we       = 1'b0;
    wb_sel       = 2'b00;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        S_EXEC: begin
          if (r_cls == C_BRANCH) begin
            pc_we  = 1'b1;
            pc_sel = br_taken ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_sel_data = 1'b1;
          mem_we       = (r_cls == C_STORE);
          pc_we        = mem_ready && (r_cls == C_STORE);
        end
        S_WB: begin
          reg_we = w_rd_nz;
          pc_we  = 1'b1;
          case (r_cls)
            C_LOAD:  wb_sel = 2'b01;
            C_JAL:   begin wb_sel = 2'b10; pc_sel = 2'b01; end
            C_JALR:  begin wb_sel = 2'b10; pc_sel = 2'b10; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign imm_sel   = r_imm;
  assign alu_src_b = r_srcb;
  assign illegal   = r_illegal;
  assign state     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed + randomized bench for multicycle_ctrl; per-instruction outcomes are
// compared against a table-driven model of the instruction classes.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        br_taken;
  logic        mem_req, mem_we, mem_sel_data, ir_we, pc_we, reg_we, alu_src_b, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  imm_sel, state;

  int total = 0;
  int bad   = 0;
  bit keep_ready = 1'b0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel_data(mem_sel_data), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_src_b(alu_src_b), .imm_sel(imm_sel), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Instruction class table: 0 R,1 I-ALU,2 LOAD,3 STORE,4 BRANCH,5 LUI,6 AUIPC,7 JAL,8 JALR
  logic [6:0] op_tab  [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
  int         imm_tab [9] = '{0, 1, 1, 2, 3, 4, 4, 5, 1};
  int         srcb_tab[9] = '{0, 1, 1, 1, 0, 1, 1, 1, 1};

  function automatic int cls_of(input logic [6:0] op);
    for (int k = 0; k < 9; k++) if (op_tab[k] == op) return k;
    return -1;
  endfunction

  // Runs one instruction from FETCH (called at a negedge) until FETCH is re-entered.
  task automatic run_instr(input string nm, input logic [31:0] ins, input int fw,
                           input int mw, input bit bt);
    int fl, ml, cyc, irc, pcc, rgc, mwc, msc, viol;
    int c, e_cyc, e_rg, e_ws, e_ps;
    logic [1:0]  psel, wsel;
    logic [2:0]  ims;
    logic        asb;
    logic [95:0] sig, e_sig;
    bit done, ldst, wr;
    instr = ins; br_taken = bt;
    fl = fw; ml = mw; cyc = 0; irc = 0; pcc = 0; rgc = 0; mwc = 0; msc = 0; viol = 0;
    psel = 2'd3; wsel = 2'd3; ims = 3'd7; asb = 1'bx; sig = '0; done = 0;
    while (!done && cyc < 60) begin
      if (mem_req) begin
        if (state == 3'd0) begin mem_ready = (fl == 0); if (fl > 0) fl--; end
        else               begin mem_ready = (ml == 0); if (ml > 0) ml--; end
      end else begin
        mem_ready = keep_ready ? 1'b1 : 1'($urandom_range(0, 1));
      end
      #1;
      sig = {sig[92:0], state};
      if (ir_we)        irc++;
      if (pc_we)        begin pcc++; psel = pc_sel; end
      if (reg_we)       begin rgc++; wsel = wb_sel; end
      if (mem_we)       mwc++;
      if (mem_sel_data) msc++;
      if (state == 3'd2) begin ims = imm_sel; asb = alu_src_b; end
      if (mem_req && !mem_ready && (ir_we || pc_we || reg_we)) viol++;
      @(posedge clk);
      cyc++;
      #1;
      if (state == 3'd0 && irc > 0) done = 1;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    // Expected behaviour from instruction class.
    c    = cls_of(ins[6:0]);
    ldst = (c == 2 || c == 3);
    wr   = !(c == 3 || c == 4);
    e_cyc = ((c == 4) ? 3 : (c == 2) ? 5 : 4) + fw + (ldst ? mw : 0);
    e_rg  = (wr && ins[11:7] != 5'd0) ? 1 : 0;
    e_ws  = (e_rg == 0) ? 3 : (c == 2) ? 1 : (c == 7 || c == 8) ? 2 : 0;
    e_ps  = (c == 4) ? int'(bt) : (c == 7) ? 1 : (c == 8) ? 2 : 0;
    e_sig = '0;
    for (int k = 0; k <= fw; k++) e_sig = {e_sig[92:0], 3'd0};
    e_sig = {e_sig[89:0], 3'd1, 3'd2};
    if (ldst) for (int k = 0; k <= mw; k++) e_sig = {e_sig[92:0], 3'd3};
    if (wr) e_sig = {e_sig[92:0], 3'd4};
    chk({nm, ".done"},    done, 1);
    chk({nm, ".cycles"},  cyc, e_cyc);
    chk({nm, ".states"},  sig, e_sig);
    chk({nm, ".ir_we"},   irc, 1);
    chk({nm, ".pc_we"},   pcc, 1);
    chk({nm, ".pc_sel"},  psel, e_ps);
    chk({nm, ".reg_we"},  rgc, e_rg);
    chk({nm, ".wb_sel"},  wsel, e_ws);
    chk({nm, ".imm_sel"}, ims, imm_tab[c]);
    chk({nm, ".alu_b"},   asb, srcb_tab[c]);
    chk({nm, ".mem_we"},  mwc, (c == 3) ? mw + 1 : 0);
    chk({nm, ".sel_data"}, msc, ldst ? mw + 1 : 0);
    chk({nm, ".we_in_wait"}, viol, 0);
    chk({nm, ".fetch_imm"}, imm_sel, 0);
  endtask

  initial begin
    int n, tv, k, idx;
    logic [31:0] ri;
    rst = 1'b0; instr = 32'h0; mem_ready = 1'b1; br_taken = 1'b0;
    #3;
    chk("rst.mem_req", mem_req, 0);
    chk("rst.state",   state, 0);
    chk("rst.illegal", illegal, 0);
    chk("rst.ir_we",   ir_we, 0);
    chk("rst.imm_sel", imm_sel, 0);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    chk("rel.mem_req", mem_req, 1);
    chk("rel.state",   state, 0);
    @(negedge clk);

    keep_ready = 1'b1;
    run_instr("add",  32'h002081B3, 0, 0, 1'b0);
    keep_ready = 1'b0;
    run_instr("lw",   32'h0040A183, 0, 2, 1'b0);
    run_instr("beqT", 32'h00208463, 0, 0, 1'b1);
    run_instr("beqN", 32'h00208463, 0, 0, 1'b0);
    run_instr("sw",   32'h0020A223, 0, 0, 1'b0);
    run_instr("jal",  32'h008000EF, 0, 0, 1'b0);
    run_instr("lwF",  32'h0040A183, 2, 1, 1'b0);

    // Illegal opcode: trap and stay there until reset.
    instr = 32'h0000007F;
    n = 0;
    while (state != 3'd5 && n < 10) begin
      mem_ready = (state == 3'd0);
      @(negedge clk); n++;
    end
    mem_ready = 1'b0;
    chk("trap.state", state, 5);
    tv = 0; k = 0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (illegal === 1'b1 && state == 3'd5) k++;
      if (mem_req || ir_we || pc_we || reg_we || imm_sel != 3'd0) tv++;
      @(negedge clk);
    end
    chk("trap.sticky", k, 20);
    chk("trap.quiet",  tv, 0);
    #2 rst = 1'b0;
    #1;
    chk("trap.rst_illegal", illegal, 0);
    chk("trap.rst_state",   state, 0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("trap.restart_req", mem_req, 1);
    @(negedge clk);
    run_instr("addR", 32'h002081B3, 0, 0, 1'b0);

    // Reset while a load is waiting in MEM.
    instr = 32'h0040A183;
    n = 0;
    while (state != 3'd3 && n < 10) begin
      mem_ready = (state == 3'd0);
      @(negedge clk); n++;
    end
    mem_ready = 1'b0;
    #1;
    chk("mrst.in_mem",  state, 3);
    chk("mrst.req_pre", mem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("mrst.mem_req", mem_req, 0);
    chk("mrst.we",      {ir_we, pc_we, reg_we}, 0);
    chk("mrst.state",   state, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mrst.restart", mem_req, 1);
    @(negedge clk);
    run_instr("swR", 32'h0020A223, 1, 2, 1'b0);

    // Randomized instructions across all classes, waits and rd values.
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 8);
      ri  = $urandom;
      ri[6:0] = op_tab[idx];
      if ($urandom_range(0, 3) == 0) ri[11:7] = 5'd0;
      run_instr($sformatf("rnd%0d", i), ri, $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
